// File: rtl/por_pkg.sv
// Shared types for the power-on/reset sequencer.
package por_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } state_t;

endpackage

// File: rtl/por_lock_filter.sv
// One PLL lock input: multi-flop synchroniser followed by a saturating
// consecutive-high filter. lock_ok is registered.
module por_lock_filter #(
  parameter int unsigned SYNC_STAGES        = 3,
  parameter int unsigned LOCK_FILTER_CYCLES = 32
) (
  input  logic clk_input,
  input  logic rst_input,
  input  logic pll_locked,
  output logic lock_ok
);

  localparam int unsigned   FW        = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(LOCK_FILTER_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic [FW-1:0]          cnt;

  // Synchroniser chain; resets to "unlocked".
  always_ff @(posedge clk_input) begin
    if (rst_input) sync <= '0;
    else           sync <= {sync[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s = sync[SYNC_STAGES-1];

  // Saturating filter; any low sample restarts it.
  always_ff @(posedge clk_input) begin
    if (rst_input || !lock_s) begin
      cnt     <= '0;
      lock_ok <= 1'b0;
    end else if (cnt != FILT_MAX) begin
      cnt     <= cnt + FW'(1);
      lock_ok <= (cnt == FILT_LAST);
    end
  end

endmodule

// File: rtl/por_sequencer.sv
// Power-on/reset sequencer: synchronised external reset plus filtered PLL
// locks gate a staggered release of NUM_RST active-low resets.
// Optional feature macro: POR_LOCK_TIMEOUT_EN (WAIT_LOCK timeout + lock_timeout).
module por_sequencer
  import por_pkg::*;
#(
  parameter int unsigned NUM_LOCKS          = 2,
  parameter int unsigned NUM_RST            = 5,
  parameter int unsigned SYNC_STAGES        = 3,
  parameter int unsigned LOCK_FILTER_CYCLES = 32,
  parameter int unsigned HOLD_CYCLES        = 1024,
  parameter int unsigned STAGE_GAP_CYCLES   = 16,
  parameter int unsigned CNT_W              = 16
`ifdef POR_LOCK_TIMEOUT_EN
  ,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                 clk_input,
  input  logic                 rst_input,
  input  logic                 ext_rst_n_input,
  input  logic [NUM_LOCKS-1:0] pll_locked,
  input  logic [NUM_LOCKS-1:0] lock_mask,
  input  logic                 sw_rst_req,
  output logic [NUM_RST-1:0]   rst_n_out,
  output logic                 released,
  output logic                 lock_lost,
  input  logic                 lock_lost_clr,
  output logic                 lock_timeout,
  output logic [STATE_W-1:0]   state_out
);

  localparam int unsigned      IDX_W     = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RST - 1);

  state_t                 state, state_d;
  logic [CNT_W-1:0]       hold_cnt, hold_d;
  logic [CNT_W-1:0]       gap_cnt, gap_d;
  logic [IDX_W-1:0]       idx, idx_d;
  logic [NUM_RST-1:0]     rst_n_d;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic [NUM_LOCKS-1:0]   lock_ok;
  logic                   ext_ok;
  logic                   all_ok;
  logic                   lock_abort;
  logic                   abort;

`ifdef POR_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt, to_d;
  logic             to_set;
`endif

  // External reset synchroniser; resets to "reset asserted".
  always_ff @(posedge clk_input) begin
    if (rst_input) ext_sync <= '0;
    else           ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_rst_n_input};
  end

  assign ext_ok = ext_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_lock
    por_lock_filter #(
      .SYNC_STAGES        (SYNC_STAGES),
      .LOCK_FILTER_CYCLES (LOCK_FILTER_CYCLES)
    ) u_filter (
      .clk_input  (clk_input),
      .rst_input  (rst_input),
      .pll_locked (pll_locked[i]),
      .lock_ok    (lock_ok[i])
    );
  end

  assign all_ok     = &(lock_ok | lock_mask);
  assign lock_abort = !all_ok && ((state == RELEASE) || (state == RUN));
  assign abort      = !ext_ok || sw_rst_req || lock_abort;

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    gap_d   = gap_cnt;
    idx_d   = idx;
    rst_n_d = rst_n_out;
`ifdef POR_LOCK_TIMEOUT_EN
    to_d    = '0;
    to_set  = 1'b0;
`endif
    if (abort) begin
      state_d = HOLD;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_d = WAIT_LOCK;
            hold_d  = '0;
          end else begin
            hold_d = hold_cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (all_ok) begin
            state_d = RELEASE;
            idx_d   = '0;
            gap_d   = '0;
          end
`ifdef POR_LOCK_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state_d = HOLD;
            hold_d  = '0;
            to_set  = 1'b1;
          end else begin
            to_d = to_cnt + CNT_W'(1);
          end
`endif
        end
        RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_d = '0;
            for (int unsigned k = 0; k < NUM_RST; k++) begin
              if (IDX_W'(k) == idx) rst_n_d[k] = 1'b1;
            end
            if (idx == IDX_LAST) begin
              state_d = RUN;
              idx_d   = '0;
            end else begin
              idx_d = idx + IDX_W'(1);
            end
          end else begin
            gap_d = gap_cnt + CNT_W'(1);
          end
        end
        RUN: state_d = RUN;
        default: begin
          state_d = HOLD;
          rst_n_d = '0;
        end
      endcase
    end
  end

  // FSM state, counters and sequenced reset outputs.
  always_ff @(posedge clk_input) begin
    if (rst_input) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
      rst_n_out <= '0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_d;
      gap_cnt   <= gap_d;
      idx       <= idx_d;
      rst_n_out <= rst_n_d;
    end
  end

  // Sticky lock-loss flag; a new loss beats a clear in the same cycle.
  always_ff @(posedge clk_input) begin
    if (rst_input)          lock_lost <= 1'b0;
    else if (lock_abort)    lock_lost <= 1'b1;
    else if (lock_lost_clr) lock_lost <= 1'b0;
  end

`ifdef POR_LOCK_TIMEOUT_EN
  // WAIT_LOCK timeout counter and its sticky flag.
  always_ff @(posedge clk_input) begin
    if (rst_input) begin
      to_cnt       <= '0;
      lock_timeout <= 1'b0;
    end else begin
      to_cnt <= to_d;
      if (to_set)             lock_timeout <= 1'b1;
      else if (lock_lost_clr) lock_timeout <= 1'b0;
    end
  end
`else
  assign lock_timeout = 1'b0;
`endif

  assign released  = (state == RUN);
  assign state_out = state;

endmodule

// File: tb/tb_por_sequencer.sv
// Directed bench for por_sequencer: SYNC=2, FILTER=4, HOLD=8, GAP=2,
// NUM_RST=3, NUM_LOCKS=2. Build with POR_LOCK_TIMEOUT_EN for the timeout case.
module tb_por_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_rst_n = 1'b1;
  logic [1:0] pll_locked = 2'b11;
  logic [1:0] lock_mask = 2'b00;
  logic       sw_rst_req = 1'b0;
  logic       lock_lost_clr = 1'b0;
  logic [2:0] rst_n_out;
  logic       released;
  logic       lock_lost;
  logic       lock_timeout;
  logic [2:0] state_out;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          now = 0;

  por_sequencer #(
    .NUM_LOCKS          (2),
    .NUM_RST            (3),
    .SYNC_STAGES        (2),
    .LOCK_FILTER_CYCLES (4),
    .HOLD_CYCLES        (8),
    .STAGE_GAP_CYCLES   (2),
`ifdef POR_LOCK_TIMEOUT_EN
    .CNT_W              (16),
    .LOCK_TIMEOUT_CYCLES(16)
`else
    .CNT_W              (16)
`endif
  ) dut (
    .clk_input       (clk),
    .rst_input       (rst),
    .ext_rst_n_input (ext_rst_n),
    .pll_locked      (pll_locked),
    .lock_mask       (lock_mask),
    .sw_rst_req      (sw_rst_req),
    .rst_n_out       (rst_n_out),
    .released        (released),
    .lock_lost       (lock_lost),
    .lock_lost_clr   (lock_lost_clr),
    .lock_timeout    (lock_timeout),
    .state_out       (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic upto(input int t);
    while (now < t) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_state", 8'(state_out), 8'd0);
    chk("rst_outs", 8'(rst_n_out), 8'd0);
    chk("rst_released", 8'(released), 8'd0);
    chk("rst_lock_lost", 8'(lock_lost), 8'd0);
    chk("rst_timeout", 8'(lock_timeout), 8'd0);
    rst = 1'b0;
    now = 0;
  endtask

  initial begin
    // Power-up: locks and ext high throughout
    pll_locked = 2'b11; lock_mask = 2'b00; ext_rst_n = 1'b1;
    do_reset();
    upto(9);  chk("pu_hold9", 8'(state_out), 8'd0);
    upto(10); chk("pu_wait10", 8'(state_out), 8'd1);
    upto(11); chk("pu_rel11", 8'(state_out), 8'd2);
              chk("pu_out11", 8'(rst_n_out), 8'b000);
    upto(12); chk("pu_out12", 8'(rst_n_out), 8'b000);
    upto(13); chk("pu_out13", 8'(rst_n_out), 8'b001);
    upto(14); chk("pu_out14", 8'(rst_n_out), 8'b001);
    upto(15); chk("pu_out15", 8'(rst_n_out), 8'b011);
    upto(16); chk("pu_rlsd16", 8'(released), 8'd0);
    upto(17); chk("pu_out17", 8'(rst_n_out), 8'b111);
              chk("pu_rlsd17", 8'(released), 8'd1);
              chk("pu_run17", 8'(state_out), 8'd3);

    // Lock loss in RUN, then restore
    upto(20); pll_locked = 2'b01;
    upto(23); chk("ll_out23", 8'(rst_n_out), 8'b111);
              chk("ll_run23", 8'(state_out), 8'd3);
              lock_lost_clr = 1'b1;
    upto(24); chk("ll_out24", 8'(rst_n_out), 8'b000);
              chk("ll_hold24", 8'(state_out), 8'd0);
              chk("ll_lost_setwins", 8'(lock_lost), 8'd1);
              chk("ll_rlsd24", 8'(released), 8'd0);
              pll_locked = 2'b11;
    upto(25); chk("ll_lost_clr", 8'(lock_lost), 8'd0);
              lock_lost_clr = 1'b0;
    upto(31); chk("ll_hold31", 8'(state_out), 8'd0);
    upto(32); chk("ll_wait32", 8'(state_out), 8'd1);
    upto(33); chk("ll_rel33", 8'(state_out), 8'd2);
    upto(35); chk("ll_out35", 8'(rst_n_out), 8'b001);
    upto(39); chk("ll_out39", 8'(rst_n_out), 8'b111);
              chk("ll_rlsd39", 8'(released), 8'd1);

    // Software reset in RELEASE with idx=1
    do_reset();
    upto(14); chk("sw_out14", 8'(rst_n_out), 8'b001);
              sw_rst_req = 1'b1;
    upto(15); chk("sw_out15", 8'(rst_n_out), 8'b000);
              chk("sw_hold15", 8'(state_out), 8'd0);
              chk("sw_lost15", 8'(lock_lost), 8'd0);
              sw_rst_req = 1'b0;
    upto(22); chk("sw_hold22", 8'(state_out), 8'd0);
    upto(23); chk("sw_wait23", 8'(state_out), 8'd1);
    upto(24); chk("sw_rel24", 8'(state_out), 8'd2);
    upto(28); chk("sw_out28", 8'(rst_n_out), 8'b011);
    upto(30); chk("sw_out30", 8'(rst_n_out), 8'b111);
              chk("sw_run30", 8'(state_out), 8'd3);

    // External reset low for 20 cycles while in RUN
    upto(32); ext_rst_n = 1'b0;
    upto(34); chk("ext_out34", 8'(rst_n_out), 8'b111);
    upto(35); chk("ext_out35", 8'(rst_n_out), 8'b000);
              chk("ext_hold35", 8'(state_out), 8'd0);
              chk("ext_lost35", 8'(lock_lost), 8'd0);
    upto(52); ext_rst_n = 1'b1;
    upto(61); chk("ext_hold61", 8'(state_out), 8'd0);
    upto(62); chk("ext_wait62", 8'(state_out), 8'd1);
    upto(63); chk("ext_rel63", 8'(state_out), 8'd2);

    // One-cycle glitch on lock 0 during WAIT_LOCK restarts its filter
    pll_locked = 2'b10;
    do_reset();
    upto(10); chk("gl_wait10", 8'(state_out), 8'd1);
              pll_locked = 2'b11;
    upto(13); pll_locked = 2'b10;
    upto(14); pll_locked = 2'b11;
    upto(17); chk("gl_wait17", 8'(state_out), 8'd1);
    upto(20); chk("gl_wait20", 8'(state_out), 8'd1);
    upto(21); chk("gl_rel21", 8'(state_out), 8'd2);

    // Masked lock 0 is ignored; unmasking while it is low aborts RUN
    lock_mask = 2'b01; pll_locked = 2'b10;
    do_reset();
    upto(10); chk("mk_wait10", 8'(state_out), 8'd1);
    upto(11); chk("mk_rel11", 8'(state_out), 8'd2);
    upto(17); chk("mk_out17", 8'(rst_n_out), 8'b111);
              pll_locked = 2'b11;
    upto(19); pll_locked = 2'b10;
    upto(25); chk("mk_run25", 8'(state_out), 8'd3);
              chk("mk_lost25", 8'(lock_lost), 8'd0);
              lock_mask = 2'b00;
    upto(26); chk("mk_out26", 8'(rst_n_out), 8'b000);
              chk("mk_lost26", 8'(lock_lost), 8'd1);

    // Locks never arrive: timeout (feature) or indefinite wait
    lock_mask = 2'b00; pll_locked = 2'b00;
    do_reset();
    upto(10); chk("to_wait10", 8'(state_out), 8'd1);
`ifdef POR_LOCK_TIMEOUT_EN
    upto(25); chk("to_wait25", 8'(state_out), 8'd1);
              chk("to_flag25", 8'(lock_timeout), 8'd0);
    upto(26); chk("to_hold26", 8'(state_out), 8'd0);
              chk("to_flag26", 8'(lock_timeout), 8'd1);
              lock_lost_clr = 1'b1;
    upto(27); chk("to_clr27", 8'(lock_timeout), 8'd0);
              lock_lost_clr = 1'b0;
    upto(33); chk("to_hold33", 8'(state_out), 8'd0);
    upto(34); chk("to_wait34", 8'(state_out), 8'd1);
`else
    upto(26); chk("nt_wait26", 8'(state_out), 8'd1);
              chk("nt_flag26", 8'(lock_timeout), 8'd0);
    upto(40); chk("nt_wait40", 8'(state_out), 8'd1);
              chk("nt_flag40", 8'(lock_timeout), 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before limit");
    $fatal(1, "watchdog expired");
  end

endmodule
